bcd_counter_n: RTL and testbench



---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_counter_n.sv | 121 ++++++++++++
 tb/tb_bcd_counter_n.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, the digit clamp used on load, and the per-cycle
// operation codes used by the counter's priority logic.
package bcd_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_LOAD  = 3'd2,
        OP_UP    = 3'd3,
        OP_DN    = 3'd4
    } bcd_op_e;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit stage: +1 with carry out or -1 with borrow out.
// Chained from the least significant digit upward by bcd_counter_n.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] cur,
    input  logic       up,
    input  logic       dn,
    output logic [3:0] nxt,
    output logic       co,
    output logic       bo
);

    always_comb begin
        nxt = cur;
        co  = 1'b0;
        bo  = 1'b0;
        if (up && !dn) begin
            if (cur >= BCD_MAX) begin
                nxt = BCD_MIN;
                co  = 1'b1;
            end else begin
                nxt = cur + 4'd1;
            end
        end else if (dn && !up) begin
            if (cur == BCD_MIN) begin
                nxt = BCD_MAX;
                bo  = 1'b1;
            end else begin
                nxt = cur - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with rising-edge (or level) request detection,
// synchronous clear/load, and wrap-or-saturate behaviour at the range ends.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SATURATE    = 0,
    parameter int EDGE_DETECT = 1
) (
    input  logic                  clk_50Mhz,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  borrow,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

    logic [4*DIGITS-1:0] r_count;
    logic                r_carry;
    logic                r_borrow;
    logic                r_inc_d;
    logic                r_dec_d;

    logic                w_inc_ev;
    logic                w_dec_ev;
    bcd_op_e             w_op;
    logic [DIGITS:0]     w_up;
    logic [DIGITS:0]     w_dn;
    logic [4*DIGITS-1:0] w_step;
    logic [4*DIGITS-1:0] w_load_clamped;

    generate
        if (EDGE_DETECT != 0) begin : g_edge
            assign w_inc_ev = inc & ~r_inc_d;
            assign w_dec_ev = dec & ~r_dec_d;
        end else begin : g_level
            assign w_inc_ev = inc;
            assign w_dec_ev = dec;
        end
    endgenerate

    // Simultaneous inc and dec events cancel and fall through to hold.
    always_comb begin
        w_op = OP_HOLD;
        if (clear)
            w_op = OP_CLEAR;
        else if (load)
            w_op = OP_LOAD;
        else if (w_inc_ev && !w_dec_ev)
            w_op = OP_UP;
        else if (w_dec_ev && !w_inc_ev)
            w_op = OP_DN;
    end

    assign w_up[0] = (w_op == OP_UP);
    assign w_dn[0] = (w_op == OP_DN);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .cur (r_count[gi*BCD_W +: BCD_W]),
                .up  (w_up[gi]),
                .dn  (w_dn[gi]),
                .nxt (w_step[gi*BCD_W +: BCD_W]),
                .co  (w_up[gi+1]),
                .bo  (w_dn[gi+1])
            );
            assign w_load_clamped[gi*BCD_W +: BCD_W] =
                bcd_clamp(load_value[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    // A carry/borrow out of the top digit marks a wrap of the whole range.
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_inc_d  <= 1'b0;
            r_dec_d  <= 1'b0;
        end else begin
            r_inc_d  <= inc;
            r_dec_d  <= dec;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            case (w_op)
                OP_CLEAR: r_count <= '0;
                OP_LOAD:  r_count <= w_load_clamped;
                OP_UP: begin
                    if (!(w_up[DIGITS] && SATURATE != 0)) begin
                        r_count <= w_step;
                        r_carry <= w_up[DIGITS];
                    end
                end
                OP_DN: begin
                    if (!(w_dn[DIGITS] && SATURATE != 0)) begin
                        r_count  <= w_step;
                        r_borrow <= w_dn[DIGITS];
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    assign count  = r_count;
    assign carry  = r_carry;
    assign borrow = r_borrow;
    assign at_max = (r_count == ALL_NINES);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: a vector table on a 2-digit wrapping edge
// counter, plus sequences for level mode, saturation and asynchronous reset.
module tb_bcd_counter_n;

    logic        clk_50Mhz = 1'b0;
    logic        rst_n;
    logic        inc, dec, clear, load;
    logic [15:0] load_value;

    logic [7:0]  cnt_a, cnt_b, cnt_c;
    logic [15:0] cnt_d;
    logic        car_a, bor_a, max_a, min_a;
    logic        car_b, bor_b, max_b, min_b;
    logic        car_c, bor_c, max_c, min_c;
    logic        car_d, bor_d, max_d, min_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk_50Mhz = ~clk_50Mhz;

    // A: 2 digits, wrap, edge
    bcd_counter_n #(.DIGITS(2), .SATURATE(0), .EDGE_DETECT(1)) u_a (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .inc(inc), .dec(dec),
        .clear(clear), .load(load), .load_value(load_value[7:0]),
        .count(cnt_a), .carry(car_a), .borrow(bor_a), .at_max(max_a), .at_min(min_a));
    // B: 2 digits, wrap, level
    bcd_counter_n #(.DIGITS(2), .SATURATE(0), .EDGE_DETECT(0)) u_b (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .inc(inc), .dec(dec),
        .clear(clear), .load(load), .load_value(load_value[7:0]),
        .count(cnt_b), .carry(car_b), .borrow(bor_b), .at_max(max_b), .at_min(min_b));
    // C: 2 digits, saturate, edge
    bcd_counter_n #(.DIGITS(2), .SATURATE(1), .EDGE_DETECT(1)) u_c (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .inc(inc), .dec(dec),
        .clear(clear), .load(load), .load_value(load_value[7:0]),
        .count(cnt_c), .carry(car_c), .borrow(bor_c), .at_max(max_c), .at_min(min_c));
    // D: 4 digits, wrap, edge
    bcd_counter_n #(.DIGITS(4), .SATURATE(0), .EDGE_DETECT(1)) u_d (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .inc(inc), .dec(dec),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_d), .carry(car_d), .borrow(bor_d), .at_max(max_d), .at_min(min_d));

    typedef struct {
        logic       inc;
        logic       dec;
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] exp_cnt;
        logic       exp_c;
        logic       exp_b;
        logic       exp_max;
        logic       exp_min;
    } vec_t;

    vec_t vec [20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i, input logic d, input logic c,
                         input logic l, input logic [15:0] v);
        @(negedge clk_50Mhz);
        inc = i; dec = d; clear = c; load = l; load_value = v;
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inc = 0; dec = 0; clear = 0; load = 0; load_value = '0;
        repeat (2) @(negedge clk_50Mhz);
        rst_n = 1'b1;
    endtask

    initial begin
        logic carry_seen;

        //           inc dec clr ld  lv     cnt    c  b  max min
        vec[0]  = '{0, 0, 0, 1, 8'h98, 8'h98, 0, 0, 0, 0};
        vec[1]  = '{1, 0, 0, 0, 8'h00, 8'h99, 0, 0, 1, 0};
        vec[2]  = '{0, 0, 0, 0, 8'h00, 8'h99, 0, 0, 1, 0};
        vec[3]  = '{1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1};
        vec[4]  = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1};
        vec[5]  = '{0, 1, 0, 0, 8'h00, 8'h99, 0, 1, 1, 0};
        vec[6]  = '{0, 1, 0, 0, 8'h00, 8'h99, 0, 0, 1, 0};
        vec[7]  = '{0, 0, 0, 0, 8'h00, 8'h99, 0, 0, 1, 0};
        vec[8]  = '{1, 1, 0, 0, 8'h00, 8'h99, 0, 0, 1, 0};
        vec[9]  = '{0, 0, 0, 0, 8'h00, 8'h99, 0, 0, 1, 0};
        vec[10] = '{0, 0, 1, 1, 8'h45, 8'h00, 0, 0, 0, 1};
        vec[11] = '{0, 0, 0, 1, 8'hAB, 8'h99, 0, 0, 1, 0};
        vec[12] = '{0, 0, 0, 1, 8'h3F, 8'h39, 0, 0, 0, 0};
        vec[13] = '{1, 0, 0, 1, 8'h20, 8'h20, 0, 0, 0, 0};
        vec[14] = '{1, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0, 0};
        vec[15] = '{0, 1, 0, 0, 8'h00, 8'h19, 0, 0, 0, 0};
        vec[16] = '{0, 0, 0, 0, 8'h00, 8'h19, 0, 0, 0, 0};
        vec[17] = '{1, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0, 0};
        vec[18] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1};
        vec[19] = '{0, 1, 0, 0, 8'h00, 8'h99, 0, 1, 1, 0};

        // Reset state, checked while rst_n is still low
        rst_n = 1'b0;
        inc = 0; dec = 0; clear = 0; load = 0; load_value = '0;
        repeat (2) @(negedge clk_50Mhz);
        chk("rst_count_d", cnt_d, 16'h0000);
        chk("rst_carry", {15'd0, car_a}, 16'd0);
        chk("rst_borrow", {15'd0, bor_a}, 16'd0);
        chk("rst_at_min", {15'd0, min_d}, 16'd1);
        chk("rst_at_max", {15'd0, max_d}, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vec[i].inc, vec[i].dec, vec[i].clr, vec[i].ld, {8'h00, vec[i].lv});
            $display("vec %0d: inc=%b dec=%b clr=%b ld=%b lv=%h -> count=%h carry=%b borrow=%b",
                     i, vec[i].inc, vec[i].dec, vec[i].clr, vec[i].ld, vec[i].lv,
                     cnt_a, car_a, bor_a);
            chk($sformatf("vec%0d_count", i), {8'h00, cnt_a}, {8'h00, vec[i].exp_cnt});
            chk($sformatf("vec%0d_carry", i), {15'd0, car_a}, {15'd0, vec[i].exp_c});
            chk($sformatf("vec%0d_borrow", i), {15'd0, bor_a}, {15'd0, vec[i].exp_b});
            chk($sformatf("vec%0d_at_max", i), {15'd0, max_a}, {15'd0, vec[i].exp_max});
            chk($sformatf("vec%0d_at_min", i), {15'd0, min_a}, {15'd0, vec[i].exp_min});
        end

        // Twelve single-cycle inc pulses
        do_reset();
        carry_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0, 0, 16'h0000);
            carry_seen = carry_seen | car_a;
            drive(0, 0, 0, 0, 16'h0000);
            carry_seen = carry_seen | car_a;
        end
        $display("12 pulses: A=%h B=%h C=%h D=%h", cnt_a, cnt_b, cnt_c, cnt_d);
        chk("pulse12_a", {8'h00, cnt_a}, 16'h0012);
        chk("pulse12_b", {8'h00, cnt_b}, 16'h0012);
        chk("pulse12_c", {8'h00, cnt_c}, 16'h0012);
        chk("pulse12_d", cnt_d, 16'h0012);
        chk("pulse12_no_carry", {15'd0, carry_seen}, 16'd0);

        // inc held high for 50 cycles: one step in edge mode, 50 in level mode
        do_reset();
        for (int i = 0; i < 50; i++) drive(1, 0, 0, 0, 16'h0000);
        drive(0, 0, 0, 0, 16'h0000);
        $display("held 50: A=%h B=%h C=%h D=%h", cnt_a, cnt_b, cnt_c, cnt_d);
        chk("held50_edge_a", {8'h00, cnt_a}, 16'h0001);
        chk("held50_level_b", {8'h00, cnt_b}, 16'h0050);
        chk("held50_edge_d", cnt_d, 16'h0001);

        // Saturate versus wrap at both range ends
        do_reset();
        drive(0, 0, 0, 1, 16'h0099);
        drive(1, 0, 0, 0, 16'h0000);
        $display("inc from 99: A=%h carry=%b C=%h carry=%b", cnt_a, car_a, cnt_c, car_c);
        chk("sat_inc_c", {8'h00, cnt_c}, 16'h0099);
        chk("sat_inc_carry_c", {15'd0, car_c}, 16'd0);
        chk("wrap_inc_a", {8'h00, cnt_a}, 16'h0000);
        chk("wrap_inc_carry_a", {15'd0, car_a}, 16'd1);
        drive(0, 0, 1, 0, 16'h0000);
        chk("carry_one_cycle_a", {15'd0, car_a}, 16'd0);
        drive(0, 1, 0, 0, 16'h0000);
        $display("dec from 00: A=%h borrow=%b C=%h borrow=%b", cnt_a, bor_a, cnt_c, bor_c);
        chk("sat_dec_c", {8'h00, cnt_c}, 16'h0000);
        chk("sat_dec_borrow_c", {15'd0, bor_c}, 16'd0);
        chk("wrap_dec_a", {8'h00, cnt_a}, 16'h0099);
        chk("wrap_dec_borrow_a", {15'd0, bor_a}, 16'd1);

        // Asynchronous reset mid-count
        do_reset();
        drive(0, 0, 0, 1, 16'h0457);
        chk("load_0457_d", cnt_d, 16'h0457);
        drive(0, 0, 0, 0, 16'h0000);
        @(negedge clk_50Mhz);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset: D=%h at_min=%b", cnt_d, min_d);
        chk("async_rst_d", cnt_d, 16'h0000);
        chk("async_rst_at_min", {15'd0, min_d}, 16'd1);
        repeat (2) @(negedge clk_50Mhz);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
